pdm_tx: RTL and testbench



---
 rtl/pdm_pkg.sv | 27 ++
 rtl/pdm_tx_buf.sv | 28 ++
 rtl/pdm_tx.sv | 156 +++++++++++++++
 tb/tb_pdm_tx.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/pdm_pkg.sv
// Shared definitions for the PDM playback path: command encodings, FSM states
// and the buffer write request.
package pdm_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        CMD_NONE = 2'b00,
        CMD_ONCE = 2'b01,
        CMD_STOP = 2'b10,
        CMD_LOOP = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_PLAY  = 2'd2
    } state_e;

    // Word index carried at full 16-bit width; the buffer keeps only log2(DEPTH) bits.
    typedef struct packed {
        logic              en;
        logic [15:0]       idx;
        logic [WORD_W-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/pdm_tx_buf.sv
// DEPTH x 32 playback buffer: synchronous write, one-cycle synchronous read.
// A read of the word being written returns the new data.
module pdm_tx_buf
    import pdm_pkg::*;
#(
    parameter int  DEPTH = 1024,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              AHBclk,
    input  wr_req_t           wr,
    input  logic [AW-1:0]     rd_idx,
    output logic [WORD_W-1:0] rd_data
);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_idx;
    logic [15:0]       unused_idx;

    assign wr_idx     = wr.idx[AW-1:0];
    assign unused_idx = wr.idx;

    always_ff @(posedge AHBclk) begin
        if (wr.en)
            mem[wr_idx] <= wr.data;
        rd_data <= (wr.en && wr_idx == rd_idx) ? wr.data : mem[rd_idx];
    end

endmodule

// File: rtl/pdm_tx.sv
// PDM playback: serialises buffered 32-bit words MSB-first onto pdm_out with a
// divided bit clock; once or looped playback, stoppable at any point.
module pdm_tx
    import pdm_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int CLK_DIV = 8
) (
    input  logic        AHBclk,
    input  logic        rst,
    input  logic [1:0]  ctrl,
    input  logic [15:0] len,
    input  logic        wr_en,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    output logic        pdm_clk_o,
    output logic        pdm_out,
    output logic        bsy,
    output logic        done
);

    localparam int AW   = $clog2(DEPTH);
    localparam int DW   = $clog2(CLK_DIV);
    localparam int HALF = CLK_DIV / 2;
    localparam logic [AW:0]   DEPTH_L = DEPTH[AW:0];
    localparam logic [DW-1:0] DIV_END = DW'(CLK_DIV - 1);

    state_e            state_q, state_d;
    cmd_e              cmd;
    logic              loop_q, bsy_q, done_q, clk_q;
    logic [AW:0]       len_q, len_eff;
    logic [AW-1:0]     ptr_q, nxt_ptr, rd_idx;
    logic [4:0]        bit_q;
    logic [DW-1:0]     div_q;
    logic [WORD_W-1:0] sh_q, hold_q, rd_data;
    logic [16:0]       len_ext;
    logic              is_play, is_stop, end_bit, last, start, zero_play, fin, ld_hold;
    wr_req_t           wr;
    logic              unused_addr;

    assign cmd         = cmd_e'(ctrl);
    assign is_play     = (cmd == CMD_ONCE) || (cmd == CMD_LOOP);
    assign is_stop     = (cmd == CMD_STOP);
    assign len_ext     = {1'b0, len};
    assign len_eff     = (len_ext >= 17'(DEPTH)) ? DEPTH_L : len_ext[AW:0];
    assign end_bit     = (div_q == DIV_END);
    assign last        = ({1'b0, ptr_q} == len_q - 1'b1);
    assign nxt_ptr     = last ? '0 : ptr_q + 1'b1;
    assign unused_addr = ^{addr[31:18], addr[1:0]};

    // Writes only land while idle; the same-cycle play then fetches the new word.
    assign wr.en   = wr_en && (state_q == ST_IDLE);
    assign wr.idx  = addr[17:2];
    assign wr.data = din;

    pdm_tx_buf #(.DEPTH(DEPTH)) u_buf (
        .AHBclk  (AHBclk),
        .wr      (wr),
        .rd_idx  (rd_idx),
        .rd_data (rd_data)
    );

    always_ff @(posedge AHBclk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (is_play && len_eff != '0) state_d = ST_FETCH;
            ST_FETCH: state_d = is_stop ? ST_IDLE : ST_PLAY;
            ST_PLAY: begin
                if (is_stop)
                    state_d = ST_IDLE;
                else if (end_bit && bit_q == 5'd0 && last && !loop_q)
                    state_d = ST_IDLE;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        start     = (state_q == ST_IDLE) && is_play && (len_eff != '0);
        zero_play = (state_q == ST_IDLE) && is_play && (len_eff == '0);
        fin       = (state_q != ST_IDLE) && (state_d == ST_IDLE);
        ld_hold   = (state_q == ST_PLAY) && (bit_q == 5'd0) && (div_q == DW'(1));
        // Idle reads word 0 so FETCH already has it; playing reads the next word.
        rd_idx    = (state_q == ST_PLAY) ? nxt_ptr : '0;
    end

    always_ff @(posedge AHBclk) begin
        if (rst) begin
            loop_q <= 1'b0;
            len_q  <= '0;
            ptr_q  <= '0;
            bit_q  <= '0;
            div_q  <= '0;
            sh_q   <= '0;
            hold_q <= '0;
            clk_q  <= 1'b0;
            bsy_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= fin || zero_play;
            if (ld_hold)
                hold_q <= rd_data;
            case (state_q)
                ST_IDLE: if (start) begin
                    len_q  <= len_eff;
                    loop_q <= (cmd == CMD_LOOP);
                    ptr_q  <= '0;
                    bsy_q  <= 1'b1;
                end
                ST_FETCH: begin
                    sh_q  <= rd_data;
                    bit_q <= 5'd31;
                    div_q <= '0;
                    clk_q <= 1'b1;
                end
                ST_PLAY: begin
                    if (end_bit) begin
                        div_q <= '0;
                        clk_q <= 1'b1;
                        if (bit_q == 5'd0) begin
                            sh_q  <= hold_q;
                            bit_q <= 5'd31;
                            ptr_q <= nxt_ptr;
                        end else begin
                            sh_q  <= sh_q << 1;
                            bit_q <= bit_q - 5'd1;
                        end
                    end else begin
                        div_q <= div_q + 1'b1;
                        clk_q <= (int'(div_q) + 1 < HALF);
                    end
                end
                default: ;
            endcase
            if (fin) begin
                sh_q  <= '0;
                clk_q <= 1'b0;
                bsy_q <= 1'b0;
                div_q <= '0;
                bit_q <= '0;
                ptr_q <= '0;
            end
        end
    end

    assign pdm_out   = sh_q[WORD_W-1];
    assign pdm_clk_o = clk_q;
    assign bsy       = bsy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_pdm_tx.sv
// Directed bench for pdm_tx: waveform checked cycle by cycle against the
// hand-written buffer contents, plus done/bsy timing and corner cases.
module tb_pdm_tx;
    import pdm_pkg::*;

    localparam int DEPTH   = 16;
    localparam int CLK_DIV = 8;
    localparam int WCYC    = 32 * CLK_DIV;

    logic        AHBclk = 1'b0;
    logic        rst    = 1'b1;
    logic [1:0]  ctrl   = CMD_NONE;
    logic [15:0] len    = '0;
    logic        wr_en  = 1'b0;
    logic [31:0] addr   = '0;
    logic [31:0] din    = '0;
    logic        pdm_clk_o, pdm_out, bsy, done;

    int n_chk  = 0;
    int n_fail = 0;
    logic [31:0] exp_words [DEPTH];

    pdm_tx #(.DEPTH(DEPTH), .CLK_DIV(CLK_DIV)) dut (
        .AHBclk    (AHBclk),
        .rst       (rst),
        .ctrl      (ctrl),
        .len       (len),
        .wr_en     (wr_en),
        .addr      (addr),
        .din       (din),
        .pdm_clk_o (pdm_clk_o),
        .pdm_out   (pdm_out),
        .bsy       (bsy),
        .done      (done)
    );

    always #5 AHBclk = ~AHBclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge AHBclk);
        #1;
    endtask

    task automatic wr(input int idx, input logic [31:0] data);
        wr_en = 1'b1; addr = 32'(idx * 4); din = data;
        tick;
        wr_en = 1'b0;
    endtask

    // Play once; pattern expected from exp_words[0..nw-1]. poke injects a write
    // and a play command mid-playback, both of which must be ignored.
    task automatic run_once(input string tag, input int len_cmd, input int nw, input bit poke);
        int errs;
        logic [31:0] w;
        errs = 0;
        ctrl = CMD_ONCE; len = 16'(len_cmd);
        tick;
        ctrl = CMD_NONE; wr_en = 1'b0;
        chk({tag, "_bsy_rise"}, {31'b0, bsy}, 32'd1);
        for (int k = 0; k < nw * WCYC; k++) begin
            if (poke && k == 20) begin
                wr_en = 1'b1; addr = 32'h0; din = 32'hDEADBEEF; ctrl = CMD_LOOP; len = 16'd1;
            end else if (poke && k == 21) begin
                wr_en = 1'b0; ctrl = CMD_NONE;
            end
            tick;
            w = exp_words[k / WCYC];
            if (pdm_out !== w[31 - (k / CLK_DIV) % 32] || pdm_clk_o !== ((k % CLK_DIV) < CLK_DIV / 2)
                || bsy !== 1'b1 || done !== 1'b0)
                errs++;
        end
        chk({tag, "_wave_errs"}, 32'(errs), 32'd0);
        tick;
        chk({tag, "_done"}, {29'b0, done, bsy, pdm_out}, {29'b0, 3'b100});
        tick;
        chk({tag, "_done_clr"}, {31'b0, done}, 32'd0);
    endtask

    initial begin
        int errs;
        logic [31:0] w;

        tick; tick;
        chk("rst_outs", {28'b0, pdm_clk_o, pdm_out, bsy, done}, 32'd0);
        rst = 1'b0;
        tick;

        // Single word: 1, thirty 0s, 1.
        wr(0, 32'h8000_0001); exp_words[0] = 32'h8000_0001;
        run_once("t1", 1, 1, 1'b0);

        // Two words, no gap at the word boundary.
        wr(0, 32'hFFFF_0000); wr(1, 32'h0000_FFFF);
        exp_words[0] = 32'hFFFF_0000; exp_words[1] = 32'h0000_FFFF;
        run_once("t2", 2, 2, 1'b0);

        // Loop len=2, stop after 100 bit periods.
        ctrl = CMD_LOOP; len = 16'd2;
        tick;
        ctrl = CMD_NONE;
        errs = 0;
        for (int k = 0; k < 100 * CLK_DIV; k++) begin
            tick;
            w = exp_words[(k / WCYC) % 2];
            if (pdm_out !== w[31 - (k / CLK_DIV) % 32] || pdm_clk_o !== ((k % CLK_DIV) < CLK_DIV / 2)
                || done !== 1'b0)
                errs++;
        end
        chk("loop_wave_errs", 32'(errs), 32'd0);
        ctrl = CMD_STOP;
        tick;
        ctrl = CMD_NONE;
        chk("loop_stop", {28'b0, done, bsy, pdm_out, pdm_clk_o}, {28'b0, 4'b1000});
        tick;
        chk("loop_done_clr", {31'b0, done}, 32'd0);

        // Stop while idle: no done.
        ctrl = CMD_STOP;
        tick;
        ctrl = CMD_NONE;
        chk("idle_stop", {30'b0, done, bsy}, 32'd0);

        // Zero length play.
        ctrl = CMD_ONCE; len = 16'd0;
        tick;
        ctrl = CMD_NONE;
        chk("len0_pulse", {30'b0, done, bsy}, {30'b0, 2'b10});
        tick;
        chk("len0_clr", {30'b0, done, bsy}, 32'd0);

        // len beyond DEPTH clamps to DEPTH words.
        for (int i = 0; i < DEPTH; i++) begin
            exp_words[i] = {8'(i), ~8'(i), 16'h1234 + 16'(i)};
            wr(i, exp_words[i]);
        end
        run_once("clamp", 5000, DEPTH, 1'b0);

        // Write and play ignored while busy; original data replays.
        wr(0, 32'hA5C3_0F81); exp_words[0] = 32'hA5C3_0F81;
        run_once("busy_wr", 1, 1, 1'b1);
        run_once("replay", 1, 1, 1'b0);

        // Write in the same cycle as play (addr 64 aliases word 0).
        wr_en = 1'b1; addr = 32'd64; din = 32'h3C00_00C3; exp_words[0] = 32'h3C00_00C3;
        run_once("wr_play", 1, 1, 1'b0);

        // Reset mid-word, then play again from scratch.
        ctrl = CMD_ONCE; len = 16'd1;
        tick;
        ctrl = CMD_NONE;
        for (int k = 0; k < 50; k++) tick;
        rst = 1'b1;
        tick;
        chk("mid_rst", {28'b0, pdm_clk_o, pdm_out, bsy, done}, 32'd0);
        rst = 1'b0;
        wr(0, 32'h8000_0001); exp_words[0] = 32'h8000_0001;
        run_once("post_rst", 1, 1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
